// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch controller with flush-on-redirect
// Define FETCH_PREFETCH_EN for a 2-entry prefetch buffer (1-entry otherwise).
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [CW-1:0] count;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic [31:0]   redirect_tgt;
  logic [31:0]   fpc_inc;
  logic          wr_en;
  logic          pop;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] wr_idx;

  assign redirect_tgt = REDIRECT_PC & 32'hFFFF_FFFC;
  assign fpc_inc      = fpc + 32'd4;
  assign wr_en        = (state == FETCH) && MEM_ACK && !REDIRECT;
  assign pop          = INST_VALID && INST_READY;
  assign wr_idx       = count - CW'(pop);

  assign INST_VALID = (count != '0);
  assign INST       = word_q[0];
  assign INST_PC    = pc_q[0];

  // A redirect empties the buffer outright, overriding any pop or write.
  always_comb begin
    count_nxt = count + CW'(wr_en) - CW'(pop);
    if (REDIRECT) count_nxt = '0;
  end

  // Shift-down buffer: entry 0 is always the head presented to the core.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (!REDIRECT) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (pop) begin
          word_q[i] <= word_q[i+1];
          pc_q[i]   <= pc_q[i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_idx == CW'(i))) begin
          word_q[i] <= MEM_RDATA;
          pc_q[i]   <= fpc;
        end
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      fpc      <= RESET_PC & 32'hFFFF_FFFC;
      count    <= '0;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
    end else begin
      count <= count_nxt;
      case (state)
        IDLE: begin
          if (REDIRECT) begin
            fpc      <= redirect_tgt;
            state    <= FETCH;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= redirect_tgt;
          end else if (count < DEPTH_C) begin
            state    <= FETCH;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= fpc;
          end
        end
        FETCH: begin
          if (MEM_ACK) begin
            if (REDIRECT) begin
              fpc      <= redirect_tgt;
              MEM_ADDR <= redirect_tgt;
            end else begin
              fpc <= fpc_inc;
              if (count_nxt < DEPTH_C) begin
                MEM_ADDR <= fpc_inc;
              end else begin
                state   <= IDLE;
                MEM_REQ <= 1'b0;
              end
            end
          end else if (REDIRECT) begin
            // The bus request cannot be withdrawn; its data is dropped in FLUSH.
            fpc   <= redirect_tgt;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (REDIRECT) fpc <= redirect_tgt;
          if (MEM_ACK) begin
            state    <= FETCH;
            MEM_ADDR <= REDIRECT ? redirect_tgt : fpc;
          end
        end
        default: begin
          state   <= IDLE;
          MEM_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        INST_VALID;
  logic        INST_READY;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;

  inst_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .INST_VALID(INST_VALID), .INST_READY(INST_READY), .INST(INST), .INST_PC(INST_PC),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
  );

  always #5 CLOCK = ~CLOCK;

  int unsigned total = 0;
  int unsigned passes = 0;
  int unsigned fails = 0;

  // Reference model: the core must see the linear stream from the latest target.
  logic [31:0] exp_pc;
  logic        pend_prev;
  logic [31:0] addr_prev;
  logic [31:0] done_q[$];
  int unsigned n_consumed;
  logic [31:0] old_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic ack, input logic rdy, input logic rd, input logic [31:0] rpc);
    MEM_ACK     = ack;
    INST_READY  = rdy;
    REDIRECT    = rd;
    REDIRECT_PC = rpc;
    MEM_RDATA   = mem_word(MEM_ADDR);
    if (pend_prev) begin
      check("req_hold", {31'd0, MEM_REQ}, 32'd1);
      check("addr_hold", MEM_ADDR, addr_prev);
    end
    if (MEM_REQ) check("addr_align", {30'd0, MEM_ADDR[1:0]}, 32'd0);
    if (MEM_REQ && ack) done_q.push_back(MEM_ADDR);
    if (INST_VALID && rdy) begin
      check("inst_pc", INST_PC, exp_pc);
      check("inst_word", INST, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    if (rd) exp_pc = rpc & 32'hFFFF_FFFC;
    pend_prev = MEM_REQ && !ack;
    addr_prev = MEM_ADDR;
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; MEM_ACK = 1'b0; INST_READY = 1'b0; REDIRECT = 1'b0;
    REDIRECT_PC = '0; MEM_RDATA = '0;
    exp_pc = RST_PC; pend_prev = 1'b0; addr_prev = '0; n_consumed = 0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_req", {31'd0, MEM_REQ}, 32'd0);
    check("rst_addr", MEM_ADDR, 32'd0);
    check("rst_valid", {31'd0, INST_VALID}, 32'd0);
    check("rst_inst", INST, 32'd0);
    check("rst_inst_pc", INST_PC, 32'd0);

    // Reset release: request appears one cycle later at RESET_PC.
    RESET = 1'b0;
    check("rel_req0", {31'd0, MEM_REQ}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    check("rel_req1", {31'd0, MEM_REQ}, 32'd1);
    check("rel_addr", MEM_ADDR, RST_PC);

    // Streaming with ack and ready held high.
    done_q.delete();
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("stream_cnt", done_q.size(), (DEPTH == 2) ? 32'd12 : 32'd4);
    for (int i = 0; i < 4; i++) check("stream_addr", done_q[i], RST_PC + 32'(4 * i));

    // Back-pressure: exactly DEPTH words buffered, then drained in order.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    done_q.delete();
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("bp_count", done_q.size(), 32'(DEPTH));
    check("bp_req_off", {31'd0, MEM_REQ}, 32'd0);
    check("bp_valid", {31'd0, INST_VALID}, 32'd1);
    check("bp_head_pc", INST_PC, 32'h0000_0400);
    n_consumed = 0;
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    check("drain_cnt", n_consumed, 32'(DEPTH));
    check("drain_req", {31'd0, MEM_REQ}, 32'd1);
    check("drain_addr", MEM_ADDR, 32'h0000_0400 + 32'(4 * DEPTH));

    // Redirect while a request waits: old address held, its data discarded.
    old_addr = MEM_ADDR;
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_2002);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    check("flush_addr", MEM_ADDR, old_addr);
    check("flush_valid", {31'd0, INST_VALID}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("tgt_req", {31'd0, MEM_REQ}, 32'd1);
    check("tgt_addr", MEM_ADDR, 32'h0000_2000);
    check("tgt_valid0", {31'd0, INST_VALID}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("tgt_valid1", {31'd0, INST_VALID}, 32'd1);
    check("tgt_pc", INST_PC, 32'h0000_2000);
    check("tgt_word", INST, mem_word(32'h0000_2000));

    // Redirect coinciding with ack and pop.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_3000);
    check("rdack_valid", {31'd0, INST_VALID}, 32'd0);
    check("rdack_req", {31'd0, MEM_REQ}, 32'd1);
    check("rdack_addr", MEM_ADDR, 32'h0000_3000);

    // Address wrap at the top of memory.
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("wrap_first", MEM_ADDR, 32'hFFFF_FFFC);
    done_q.delete();
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("wrap_q0", done_q[0], 32'hFFFF_FFFC);
    check("wrap_q1", done_q[1], 32'h0000_0000);

    // Reset during an outstanding request, with acks pulsed while held.
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    check("mid_req", {31'd0, MEM_REQ}, 32'd1);
    RESET = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, MEM_REQ}, 32'd0);
    MEM_ACK = 1'b1;
    repeat (2) begin
      @(posedge CLOCK);
      #1;
      check("mid_rst_valid", {31'd0, INST_VALID}, 32'd0);
    end
    MEM_ACK = 1'b0;
    RESET = 1'b0;
    exp_pc = RST_PC; pend_prev = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    check("restart_valid", {31'd0, INST_VALID}, 32'd0);
    check("restart_addr", MEM_ADDR, RST_PC);
    check("restart_req", {31'd0, MEM_REQ}, 32'd1);

    // Random traffic against the stream model.
    n_consumed = 0;
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), $urandom);
    end
    check("rand_progress", {31'd0, (n_consumed > 20)}, 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; bits [1:0] are forced to 0.
REQ-002 CLOCK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 MEM_REQ  output  1  SHALL indicate an instruction-memory read request.
REQ-005 MEM_ADDR  output  32  SHALL carry the word-aligned fetch address.
REQ-006 MEM_ACK  input  1  SHALL indicate read completion; MEM_RDATA is valid in the same cycle.
REQ-007 MEM_RDATA  input  32  SHALL carry the fetched instruction word.
REQ-008 INST_VALID  output  1  SHALL indicate that INST/INST_PC hold a valid instruction for the core.
REQ-009 INST_READY  input  1  SHALL indicate that the core accepts INST this cycle.
REQ-010 INST  output  32  SHALL carry the instruction word at the buffer head.
REQ-011 INST_PC  output  32  SHALL carry the address of INST.
REQ-012 REDIRECT  input  1  SHALL request a control-flow change: flush, then fetch from REDIRECT_PC.
REQ-013 REDIRECT_PC  input  32  SHALL give the redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-014 The block SHALL contain an instruction FIFO of DEPTH entries (see REQ-030), each holding {word, pc}, plus a fetch-PC register FPC.
REQ-015 The FSM SHALL have three states: IDLE (no request), FETCH (MEM_REQ=1, MEM_ADDR=FPC), FLUSH (MEM_REQ=1, response to be discarded).
REQ-016 In FETCH and FLUSH, MEM_REQ and MEM_ADDR SHALL stay stable until the cycle in which MEM_ACK=1; a transfer completes in a cycle where MEM_REQ&MEM_ACK=1; MEM_ACK SHALL be ignored while MEM_REQ=0.
REQ-017 At most one request SHALL be outstanding.
REQ-018 IDLE->FETCH SHALL occur when FIFO count < DEPTH and REDIRECT=0.
REQ-019 On completion in FETCH without REDIRECT: write {MEM_RDATA, FPC} into the FIFO, FPC<=FPC+4 (mod 2^32, wraps to 0 silently), then stay in FETCH if the next-cycle count < DEPTH, else go to IDLE.
REQ-020 Pop SHALL occur when INST_VALID&INST_READY; INST_VALID = (count!=0); INST/INST_PC SHALL be registered FIFO-head values; simultaneous write and pop SHALL leave count unchanged.
REQ-021 Minimum latency: MEM_ACK in cycle n -> INST_VALID=1 in cycle n+1.
REQ-022 On REDIRECT=1: the FIFO SHALL be cleared (count=0 next cycle, any same-cycle pop is overridden), any same-cycle write SHALL be dropped, and FPC<=REDIRECT_PC&~3.
REQ-023 REDIRECT in IDLE, or in FETCH coinciding with MEM_ACK: next state SHALL be FETCH at the new FPC (MEM_REQ in cycle n+1).
REQ-024 REDIRECT in FETCH without MEM_ACK: next state SHALL be FLUSH; MEM_ADDR SHALL keep the old address until the ack arrives.
REQ-025 In FLUSH: on MEM_ACK, data SHALL be discarded and the state SHALL go to FETCH at FPC; a further REDIRECT in FLUSH SHALL only update FPC.
REQ-026 INST_VALID SHALL never be 1 for any instruction fetched before the most recent REDIRECT.

Reset
REQ-027 While RESET=1: state=IDLE, count=0, FPC=RESET_PC, MEM_REQ=0, MEM_ADDR=0, INST_VALID=0, INST=0, INST_PC=0.
REQ-028 The first cycle after RESET deasserts SHALL enter FETCH, with MEM_REQ=1 and MEM_ADDR=RESET_PC one cycle later.
REQ-029 Reset asserted mid-transfer SHALL abandon the request; a late MEM_ACK SHALL be ignored because MEM_REQ=0.

Configuration
REQ-030 With FETCH_PREFETCH_EN defined, DEPTH SHALL be 2, sustaining one instruction per cycle with single-cycle MEM_ACK and INST_READY held at 1. Without it, DEPTH SHALL be 1 and the block SHALL return to IDLE after every completion.

Verification
REQ-031 Reset release, RESET_PC=0x100, MEM_ACK always 1, INST_READY=1 -> MEM_ADDR 0x100,0x104,0x108... on consecutive cycles (prefetch on); INST_PC tracks one cycle behind.
REQ-032 INST_READY=0, MEM_ACK=1 -> exactly DEPTH words buffered, then MEM_REQ=0; on READY=1, words drain in order with no loss or duplication.
REQ-033 REDIRECT to 0x2002 while FETCH is waiting (MEM_ACK=0 for 3 cycles) -> FLUSH; old data discarded; next MEM_ADDR=0x2000; INST_VALID=0 until the 0x2000 word arrives.
REQ-034 REDIRECT coincides with MEM_ACK and pop -> FIFO empty next cycle, ack data dropped, MEM_REQ to target next cycle.
REQ-035 FPC=0xFFFF_FFFC fetched -> next MEM_ADDR=0x0000_0000.
REQ-036 RESET asserted during an outstanding request, MEM_ACK pulsed during reset -> no INST_VALID; fetch restarts at RESET_PC.
